fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter WIDTH, default 16, FIFO word width; fixed at 16 in this revision.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fifo_dout  input  16  word from upstream FIFO; valid the cycle after fifo_read.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_read  output  1  one-cycle read strobe to upstream FIFO.
REQ-008 tx  output  1  UART serial line, idle high, 8N1.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 word_count  output  8  count of fully transmitted words, wraps 255->0.

Function
REQ-011 FSM states SHALL be IDLE, READ, LATCH, START, DATA, STOP; one-hot or binary encoding is acceptable.
REQ-012 IDLE: if fifo_empty=0, next state READ; otherwise stay IDLE.
REQ-013 READ: fifo_read=1 for exactly this one cycle; next state LATCH.
REQ-014 LATCH: capture fifo_dout into a 16-bit shift register, set byte_sel=0; next state START.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles; next state DATA with bit_idx=0.
REQ-016 DATA: tx = current byte bit bit_idx, LSB first, each held CLKS_PER_BIT cycles; after bit 7, next state STOP.
REQ-017 Byte order: byte_sel=0 sends fifo_dout[7:0], byte_sel=1 sends fifo_dout[15:8].
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; if byte_sel=0, set byte_sel=1 and go to START; if byte_sel=1, increment word_count and go to IDLE.
REQ-019 tx SHALL be 1 in IDLE, READ, LATCH and STOP; tx SHALL be registered (glitch-free).
REQ-020 Frame timing: one word = 20 bit periods = 20*CLKS_PER_BIT cycles from START entry to IDLE entry.
REQ-021 Back-to-back words: minimum 3 cycles (IDLE, READ, LATCH) between the end of STOP and the next START.
REQ-022 fifo_empty and fifo_dout SHALL be ignored outside IDLE and LATCH respectively.
REQ-023 fifo_read SHALL never assert while fifo_empty=1 was sampled in IDLE, and never twice per word.
REQ-024 The baud counter SHALL reset to 0 on every state entry; a bit period ends when the counter reaches CLKS_PER_BIT-1.

Reset
REQ-025 On reset=1 at a clock edge: state=IDLE, tx=1, fifo_read=0, busy=0, word_count=0, shift register=0, counters=0.
REQ-026 Reset mid-frame SHALL abort the frame; tx returns high at the next edge; the partially sent word is lost and not re-read.
REQ-027 Reset has priority over all other inputs.

Structure
REQ-028 Shared package fifo_uart_pkg SHALL hold the state enumeration and the default CLKS_PER_BIT constant.
REQ-029 Baud timing SHALL be a sub-module baud_tick (counter with clear, tick output at CLKS_PER_BIT-1); the FSM and shift register stay in fifo_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO model with 1-cycle read latency)
REQ-030 Reset: hold reset 2 cycles with fifo_empty=0 -> tx=1, fifo_read=0, busy=0, word_count=0 throughout.
REQ-031 Single word 16'hA53C -> one fifo_read pulse; tx = 0,00111100(LSB first),1,0,10100101(LSB first),1 at 4 cycles/bit; word_count=1 after 80 cycles.
REQ-032 Back-to-back words 100, 10, 250, 40 -> exactly 4 fifo_read pulses, decoded bytes 100,0,10,0,250,0,40,0, exactly 3 idle-high cycles between frames, word_count=4.
REQ-033 Empty FIFO: fifo_empty=1 for 200 cycles -> fifo_read never asserts, tx stays 1, busy=0.
REQ-034 Reset mid-frame: assert reset during DATA bit 3 of the low byte -> tx=1 next edge, state IDLE, word_count unchanged (0), no extra fifo_read.
REQ-035 Wrap: send 256 words of 16'h0001 -> word_count reaches 255 then 0; no missed or duplicated reads.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and default timing constants.
package fifo_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud
    localparam int unsigned WORD_WIDTH           = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Upstream FIFO read port: the transmitter is master (issues the read strobe),
// the FIFO is slave (supplies data and the empty flag).
interface fifo_uart_tx_if
    import fifo_uart_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
);

    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_read;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_read
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_read
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts clocks since the last clear and pulses tick on the
// final clock of each bit period, then restarts from zero.
module baud_tick
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    always_comb begin
        tick = (count == LAST);
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls 16-bit words from an upstream FIFO and sends each as two 8N1 UART
// frames, low byte first, counting completed words.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned WIDTH        = WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_uart_tx_if.master        bus,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            word_count
);

    state_t           state, state_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic             byte_sel, byte_sel_n;
    logic [WIDTH-1:0] shift_reg, shift_reg_n;
    logic [7:0]       word_count_n;
    logic             tx_n;
    logic             tick;
    logic             clear;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            byte_sel   <= 1'b0;
            shift_reg  <= '0;
            word_count <= '0;
            tx         <= 1'b1;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            byte_sel   <= byte_sel_n;
            shift_reg  <= shift_reg_n;
            word_count <= word_count_n;
            tx         <= tx_n;
        end
    end

    // The word shifts right once per data bit, so after the low byte's eight
    // shifts the high byte sits in [7:0] and the line always sends bit 0.
    always_comb begin
        state_n      = state;
        bit_idx_n    = bit_idx;
        byte_sel_n   = byte_sel;
        shift_reg_n  = shift_reg;
        word_count_n = word_count;

        unique case (state)
            IDLE: begin
                if (!bus.fifo_empty) state_n = READ;
            end
            READ: begin
                state_n = LATCH;
            end
            LATCH: begin
                shift_reg_n = bus.fifo_dout;
                byte_sel_n  = 1'b0;
                state_n     = START;
            end
            START: begin
                if (tick) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_reg_n = shift_reg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!byte_sel) begin
                        byte_sel_n = 1'b1;
                        state_n    = START;
                    end else begin
                        word_count_n = word_count + 8'd1;
                        state_n      = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes in the
    // same cycle the state does, without decode glitches.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_reg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_comb begin
        clear         = (state_n != state);
        bus.fifo_read = (state == READ);
        busy          = (state != IDLE);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at 4 clocks per bit with a 1-cycle-latency
// FIFO model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx;
    logic       busy;
    logic [7:0] word_count;

    int vectors = 0;
    int miscompares = 0;

    fifo_uart_tx_if #(.WIDTH(16)) bus ();

    fifo_uart_tx #(
        .CLKS_PER_BIT(4),
        .WIDTH       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .tx        (tx),
        .busy      (busy),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:511];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int unsigned reads = 0;
    logic        force_full = 1'b0;

    assign bus.fifo_empty = !force_full && (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_read) begin
            bus.fifo_dout <= mem[rd_ptr[8:0]];
            rd_ptr        <= rd_ptr + 1;
            reads         <= reads + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[8:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_start(output int highs, output bit timed_out);
        highs = 0;
        timed_out = 1'b0;
        while (tx !== 1'b0) begin
            if (highs >= 400) begin
                timed_out = 1'b1;
                break;
            end
            highs++;
            @(negedge clk);
        end
    endtask

    task automatic decode(output logic [19:0] bits);
        bits = '0;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 2) bits[k] = tx;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        force_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({tx, bus.fifo_read, busy, word_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: tx/read/busy/wc=%b/%b/%b/%0d required 1/0/0/0",
                         i, tx, bus.fifo_read, busy, word_count);
            end
        end
        force_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tx, bus.fifo_read, busy, word_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_release: tx/read/busy/wc=%b/%b/%b/%0d required 1/0/0/0",
                     tx, bus.fifo_read, busy, word_count);
        end
    endtask

    task automatic test_empty;
        int unsigned r0;
        r0 = reads;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.fifo_read, tx, busy} !== 3'b010) begin
                miscompares++;
                $display("FAIL empty_idle[%0d]: read/tx/busy=%b%b%b required 010",
                         i, bus.fifo_read, tx, busy);
            end
        end
        vectors++;
        if (reads != r0) begin
            miscompares++;
            $display("FAIL empty_reads: %0d reads, required 0", reads - r0);
        end
    endtask

    task automatic test_reset_midframe;
        int unsigned r0;
        int          h;
        bit          to;
        r0 = reads;
        push(16'h5A07);
        wait_start(h, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL midframe_start: no start bit seen, required one within 400 cycles");
            return;
        end
        repeat (17) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_bit3: tx=%b required 0", tx);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tx, busy, word_count} !== {1'b1, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL midframe_abort: tx/busy/wc=%b/%b/%0d required 1/0/0", tx, busy, word_count);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (reads - r0 != 1 || tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_after: reads=%0d tx=%b busy=%b required 1/1/0", reads - r0, tx, busy);
        end
    endtask

    task automatic test_single;
        int unsigned r0;
        int          h;
        bit          to;
        logic [19:0] exp;
        exp = 20'hD2A78;  // 0,00111100,1,0,10100101,1 with bit k at index k
        r0 = reads;
        push(16'hA53C);
        wait_start(h, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL single_start: no start bit seen, required one within 400 cycles");
            return;
        end
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (tx !== exp[k]) begin
                    miscompares++;
                    $display("FAIL single_tx bit %0d cycle %0d: tx=%b required %b", k, c, tx, exp[k]);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (word_count !== 8'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: wc=%0d busy=%b required 1/0", word_count, busy);
        end
        vectors++;
        if (reads - r0 != 1) begin
            miscompares++;
            $display("FAIL single_reads: %0d reads, required 1", reads - r0);
        end
    endtask

    task automatic test_back_to_back;
        int unsigned r0;
        int          h;
        bit          to;
        logic [19:0] bits;
        logic [7:0]  lo [4];
        lo = '{8'd100, 8'd10, 8'd250, 8'd40};
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r0 = reads;
        push(16'd100);
        push(16'd10);
        push(16'd250);
        push(16'd40);
        for (int i = 0; i < 4; i++) begin
            wait_start(h, to);
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL b2b_start[%0d]: no start bit seen, required one within 400 cycles", i);
                break;
            end
            if (i > 0) begin
                vectors++;
                if (h != 3) begin
                    miscompares++;
                    $display("FAIL b2b_gap[%0d]: %0d idle-high cycles, required 3", i, h);
                end
            end
            decode(bits);
            vectors++;
            if (bits[8:1] !== lo[i]) begin
                miscompares++;
                $display("FAIL b2b_low[%0d]: got %0d required %0d", i, bits[8:1], lo[i]);
            end
            vectors++;
            if (bits[18:11] !== 8'd0) begin
                miscompares++;
                $display("FAIL b2b_high[%0d]: got %0d required 0", i, bits[18:11]);
            end
            vectors++;
            if ({bits[19], bits[10], bits[9], bits[0]} !== 4'b1010) begin
                miscompares++;
                $display("FAIL b2b_framing[%0d]: stop/start/stop/start=%b required 1010",
                         i, {bits[19], bits[10], bits[9], bits[0]});
            end
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (word_count !== 8'd4 || reads - r0 != 4 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: wc=%0d reads=%0d busy=%b required 4/4/0", word_count, reads - r0, busy);
        end
    endtask

    task automatic test_wrap;
        int unsigned r0;
        logic [7:0]  prev;
        int          waited;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r0 = reads;
        for (int i = 0; i < 256; i++) push(16'h0001);
        prev = word_count;
        for (int i = 0; i < 256; i++) begin
            waited = 0;
            while (word_count === prev && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            vectors++;
            if (word_count !== 8'(i + 1)) begin
                miscompares++;
                $display("FAIL wrap_count[%0d]: wc=%0d required %0d", i, word_count, 8'(i + 1));
                break;
            end
            prev = word_count;
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (reads - r0 != 256 || busy !== 1'b0 || word_count !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_done: reads=%0d busy=%b wc=%0d required 256/0/0", reads - r0, busy, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_reset_midframe();
        test_single();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
